// File: rtl/ram_single_arb.sv
// rtl/ram_single_arb.sv - round-robin A/B arbiter for one single-port RAM (negedge write, registered read)
// Optional zero-fill of the RAM after reset: define RAM_ARB_INIT_EN.
module ram_single_arb #(
  parameter int REG_SIZE  = 36,
  parameter int FILE_SIZE = 32,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [REG_SIZE-1:0]  a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [REG_SIZE-1:0]  b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [REG_SIZE-1:0]  rdata,
  output logic [ADDR_SIZE-1:0] ram_a,
  output logic [REG_SIZE-1:0]  ram_d,
  output logic                 ram_we,
  input  logic [REG_SIZE-1:0]  ram_q,
  output logic                 init_done
);

  logic                 run;
  logic                 init_phase;
  logic [ADDR_SIZE-1:0] init_addr;
  logic                 prio_b;
  logic                 a_rv_q;
  logic                 b_rv_q;

`ifdef RAM_ARB_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t               state, state_next;
  logic [ADDR_SIZE-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == S_INIT) begin
      cnt_next = cnt + 1'b1;
      if (cnt == ADDR_SIZE'(FILE_SIZE - 1)) begin
        state_next = S_RUN;
        cnt_next   = '0;
      end
    end
  end

  assign run        = ~rst & (state == S_RUN);
  assign init_phase = ~rst & (state == S_INIT);
  assign init_addr  = cnt;
`else
  assign run        = ~rst;
  assign init_phase = 1'b0;
  assign init_addr  = '0;
`endif

  // Grant and RAM drive; with no grant the RAM bus idles on A's fields.
  always_comb begin
    a_gnt  = run & a_req & (~b_req | ~prio_b);
    b_gnt  = run & b_req & (~a_req | prio_b);
    ram_a  = a_addr;
    ram_d  = a_wdata;
    ram_we = 1'b0;
    if (init_phase) begin
      ram_a  = init_addr;
      ram_d  = '0;
      ram_we = 1'b1;
    end else if (a_gnt) begin
      ram_we = a_we;
    end else if (b_gnt) begin
      ram_a  = b_addr;
      ram_d  = b_wdata;
      ram_we = b_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
      prio_b <= 1'b0;
    end else begin
      a_rv_q <= a_gnt & ~a_we;
      b_rv_q <= b_gnt & ~b_we;
      if (a_gnt)      prio_b <= 1'b1;
      else if (b_gnt) prio_b <= 1'b0;
    end
  end

  // A reset arriving right after a read grant suppresses that return.
  assign a_rvalid  = a_rv_q & ~rst;
  assign b_rvalid  = b_rv_q & ~rst;
  assign rdata     = ram_q;
  assign init_done = run;

endmodule

// File: tb/tb_ram_single_arb.sv
// tb/tb_ram_single_arb.sv - randomized and directed bench for ram_single_arb with RAM and reference model
module tb_ram_single_arb;

`ifdef RAM_ARB_INIT_EN
  localparam int INIT_LEN = 32;
`else
  localparam int INIT_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [4:0]  a_addr = 0, b_addr = 0;
  logic [35:0] a_wdata = 0, b_wdata = 0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we, init_done;
  logic [35:0] rdata, ram_d, ram_q;
  logic [4:0]  ram_a;

  ram_single_arb #(.REG_SIZE(36), .FILE_SIZE(32), .ADDR_SIZE(5)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
    .ram_q(ram_q), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // RAM macro: write on negedge, registered read on posedge.
  logic [35:0] ram_mem [32];
  always @(negedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;
  always @(posedge clk) ram_q <= ram_mem[ram_a];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model state
  logic [35:0] ref_mem [32];
  bit          ref_valid [32];
  bit          prio_is_b = 0;
  bit          pend_a = 0, pend_b = 0, pend_known = 0;
  logic [35:0] pend_data = 0;
  int          init_left = 0;
  bit          last_eg_a = 0, last_eg_b = 0;
  logic        obs_ga, obs_gb, obs_rva, obs_rvb;
  logic [35:0] obs_rdata;

  task automatic tick(input logic r, input logic ar, input logic aw, input logic [4:0] aa,
                      input logic [35:0] ad, input logic br, input logic bw,
                      input logic [4:0] ba, input logic [35:0] bd);
    bit eg_a, eg_b, ewe, edone;
    @(posedge clk);
    #1;
    rst = r; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #2;
    obs_ga = a_gnt; obs_gb = b_gnt; obs_rva = a_rvalid; obs_rvb = b_rvalid; obs_rdata = rdata;
    check("a_rvalid", a_rvalid, 64'(pend_a & !r));
    check("b_rvalid", b_rvalid, 64'(pend_b & !r));
    if ((pend_a || pend_b) && !r && pend_known) check("rdata", rdata, 64'(pend_data));
    eg_a = 0; eg_b = 0; ewe = 0; edone = 0;
    if (!r && init_left > 0) begin
      ewe = 1;
      check("init_addr", ram_a, 64'(32 - init_left));
      check("init_data", ram_d, 0);
    end else if (!r) begin
      edone = 1;
      if (ar && (!br || !prio_is_b)) eg_a = 1;
      else if (br) eg_b = 1;
      if (eg_a) ewe = aw;
      if (eg_b) ewe = bw;
    end
    check("a_gnt", a_gnt, 64'(eg_a));
    check("b_gnt", b_gnt, 64'(eg_b));
    check("ram_we", ram_we, 64'(ewe));
    check("init_done", init_done, 64'(edone));
    if (eg_a || eg_b) check("ram_a", ram_a, 64'(eg_a ? aa : ba));
    if ((eg_a && aw) || (eg_b && bw)) check("ram_d", ram_d, 64'(eg_a ? ad : bd));
    // Advance model to the next cycle
    pend_a = eg_a && !aw;
    pend_b = eg_b && !bw;
    if (pend_a || pend_b) begin
      pend_known = ref_valid[eg_a ? aa : ba];
      pend_data  = ref_mem[eg_a ? aa : ba];
    end
    if (eg_a && aw) begin ref_mem[aa] = ad; ref_valid[aa] = 1; end
    if (eg_b && bw) begin ref_mem[ba] = bd; ref_valid[ba] = 1; end
    if (eg_a) prio_is_b = 1;
    if (eg_b) prio_is_b = 0;
    if (r) begin
      pend_a = 0; pend_b = 0; prio_is_b = 0; init_left = INIT_LEN;
      if (INIT_LEN == 0) foreach (ref_valid[i]) ref_valid[i] = 0;
    end else if (init_left > 0) begin
      ref_mem[32 - init_left] = 0;
      ref_valid[32 - init_left] = 1;
      init_left--;
    end
    last_eg_a = eg_a; last_eg_b = eg_b;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (INIT_LEN) idle();
  endtask

  logic        ra, rwa, rb, rwb, rr;
  logic [4:0]  raa, rba;
  logic [35:0] rda, rdb;
  int          n;

  initial begin
    foreach (ref_valid[i]) ref_valid[i] = 0;
    // Init sequencing: A holds a read of addr 0 from reset release
    tick(1, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    n = 0;
    while (n < 100) begin
      tick(0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
      if (obs_ga) break;
      n++;
    end
    check("init_cycles", 64'(n), 64'(INIT_LEN));
`ifdef RAM_ARB_INIT_EN
    tick(0, 1, 0, 5'd17, 0, 0, 0, 0, 0);
    check("init_rd0", obs_rdata, 0);
    tick(0, 1, 0, 5'd31, 0, 0, 0, 0, 0);
    check("init_rd17", obs_rdata, 0);
    idle();
    check("init_rd31", obs_rdata, 0);
`else
    idle();
`endif

    // Write then read back by A
    tick(0, 1, 1, 5'd5, 36'h0_000A_BCDE, 0, 0, 0, 0);
    tick(0, 1, 0, 5'd5, 0, 0, 0, 0, 0);
    idle();
    check("t1_rvalid", obs_rva, 1);
    check("t1_rdata", obs_rdata, 36'h0_000A_BCDE);
    check("t1_b_rvalid", obs_rvb, 0);

    // Both request continuously after reset: strict alternation from A
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, 5'(i), 0, 1, 0, 5'(i + 8), 0);
      check("t2_a_gnt", obs_ga, 64'(i % 2 == 0));
      check("t2_b_gnt", obs_gb, 64'(i % 2 == 1));
    end
    idle();

    // A writes, B reads the same address next cycle
    tick(0, 1, 1, 5'd3, 36'h9_1234_5678, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 0, 5'd3, 0);
    idle();
    check("t3_b_rvalid", obs_rvb, 1);
    check("t3_rdata", obs_rdata, 36'h9_1234_5678);

    // B alone three times, then conflict goes to A
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 1, 0, 5'(i), 0);
      check("t4_b_gnt", obs_gb, 1);
    end
    tick(0, 1, 0, 5'd1, 0, 1, 0, 5'd2, 0);
    check("t4_a_gnt", obs_ga, 1);
    idle();

    // Reset right after an A read grant kills the return and resets priority
    tick(0, 1, 0, 5'd5, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rvalid_n1", obs_rva, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rvalid_n2", obs_rva, 0);
    repeat (INIT_LEN) idle();
    tick(0, 1, 0, 5'd6, 0, 1, 0, 5'd7, 0);
    check("t5_a_first", obs_ga, 1);
    idle();

    // Randomized traffic; stalled requesters hold fields or withdraw
    ra = 0; rb = 0; rwa = 0; rwb = 0; raa = 0; rba = 0; rda = 0; rdb = 0;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(149) == 0);
      if (ra && !last_eg_a) begin
        if ($urandom_range(3) == 0) ra = 0;
      end else begin
        ra = 1'($urandom_range(1)); rwa = 1'($urandom_range(1));
        raa = 5'($urandom_range(31)); rda = {4'($urandom), $urandom};
      end
      if (rb && !last_eg_b) begin
        if ($urandom_range(3) == 0) rb = 0;
      end else begin
        rb = 1'($urandom_range(1)); rwb = 1'($urandom_range(1));
        rba = 5'($urandom_range(31)); rdb = {4'($urandom), $urandom};
      end
      tick(rr, ra, rwa, raa, rda, rb, rwb, rba, rdb);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
